// File: rtl/chunked_subtractor_if.sv
// Handshake and operand/result bundle for chunked_subtractor.
// master drives the request side, slave is the subtractor itself.
interface chunked_subtractor_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BorrowIN;
    logic             sat;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic             BorrowOUT;
    logic             Overflow;
    logic             Zero;

    modport master (
        output start, A, B, BorrowIN, sat,
        input  busy, done, Y, BorrowOUT, Overflow, Zero
    );

    modport slave (
        input  start, A, B, BorrowIN, sat,
        output busy, done, Y, BorrowOUT, Overflow, Zero
    );
endinterface

// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor Y = A - B - BorrowIN, CHUNK bits per clock with a
// rippled borrow between chunks. Published result and flags update only on
// the completion edge, so downstream logic never sees a partial difference.
//
// state  | meaning
// IDLE   | waiting for start; Y/flags hold the last result
// RUN    | one chunk subtracted per edge, idx selects the chunk
// DONE   | one-cycle done pulse; start still ignored here
module chunked_subtractor #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    chunked_subtractor_if.slave  bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
            $error("chunked_subtractor: WIDTH must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             sat_q, sat_d;
    logic             borrow_q, borrow_d;
    logic             bo_q, bo_d;
    logic             ov_q, ov_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] a_shift, b_shift;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_diff;
    logic [WIDTH-1:0] raw_res;
    logic             raw_ov;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] final_y;

    // Current chunk difference and the full raw result it completes.
    always_comb begin
        a_shift    = a_q >> (int'(idx_q) * CHUNK);
        b_shift    = b_q >> (int'(idx_q) * CHUNK);
        a_chunk    = a_shift[CHUNK-1:0];
        b_chunk    = b_shift[CHUNK-1:0];
        chunk_diff = {1'b0, a_chunk} - {1'b0, b_chunk} - (CHUNK+1)'(borrow_q);
        // res_q is cleared at start, so OR-ing the new chunk in is enough.
        raw_res    = res_q | (WIDTH'(chunk_diff[CHUNK-1:0]) << (int'(idx_q) * CHUNK));
        raw_ov     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (raw_res[WIDTH-1] != a_q[WIDTH-1]);
        sat_val    = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        final_y    = (sat_q && raw_ov) ? sat_val : raw_res;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        y_d      = y_q;
        idx_d    = idx_q;
        sat_d    = sat_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
        ov_d     = ov_q;
        zero_d   = zero_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.A;
                    b_d      = bus.B;
                    borrow_d = bus.BorrowIN;
                    sat_d    = bus.sat;
                    res_d    = '0;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                res_d    = raw_res;
                borrow_d = chunk_diff[CHUNK];
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    y_d     = final_y;
                    bo_d    = chunk_diff[CHUNK];
                    ov_d    = raw_ov;
                    zero_d  = (final_y == '0);
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            y_q      <= '0;
            idx_q    <= '0;
            sat_q    <= 1'b0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            ov_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            y_q      <= y_d;
            idx_q    <= idx_d;
            sat_q    <= sat_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            ov_q     <= ov_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.Y         = y_q;
    assign bus.BorrowOUT = bo_q;
    assign bus.Overflow  = ov_q;
    assign bus.Zero      = zero_q;
endmodule

// File: tb/tb_chunked_subtractor.sv
// Bench for chunked_subtractor: directed vector table on a CHUNK=4 instance
// with a result scoreboard, hand sequences for start-while-busy and reset
// abort, and a random sweep across CHUNK=16/1/8 instances.
module tb_chunked_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chunked_subtractor_if #(.WIDTH(16)) bus4 ();
    chunked_subtractor_if #(.WIDTH(16)) bus16 ();
    chunked_subtractor_if #(.WIDTH(16)) bus1 ();
    chunked_subtractor_if #(.WIDTH(16)) bus8 ();

    chunked_subtractor #(.WIDTH(16), .CHUNK(4))  dut   (.clk(clk), .rst(rst), .bus(bus4.slave));
    chunked_subtractor #(.WIDTH(16), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    chunked_subtractor #(.WIDTH(16), .CHUNK(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));
    chunked_subtractor #(.WIDTH(16), .CHUNK(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic        sat;
        logic [15:0] y;
        logic        bo;
        logic        ov;
        logic        zero;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t sb_q[$];
    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t ref_sub(input logic [15:0] a, input logic [15:0] b,
                                     input logic bin, input logic s);
        vec_t        r;
        logic [16:0] d;
        d      = {1'b0, a} - {1'b0, b} - 17'(bin);
        r.a    = a;
        r.b    = b;
        r.bin  = bin;
        r.sat  = s;
        r.bo   = d[16];
        r.ov   = (a[15] != b[15]) && (d[15] != a[15]);
        r.y    = (s && r.ov) ? (a[15] ? 16'h8000 : 16'h7FFF) : d[15:0];
        r.zero = (r.y == 16'h0000);
        return r;
    endfunction

    task automatic start_main(input vec_t v);
        @(posedge clk); #1;
        bus4.A        = v.a;
        bus4.B        = v.b;
        bus4.BorrowIN = v.bin;
        bus4.sat      = v.sat;
        bus4.start    = 1'b1;
        sb_q.push_back(v);
        @(posedge clk); #1;
        bus4.start    = 1'b0;
    endtask

    task automatic collect_main(input string name, input int exp_lat);
        int   n;
        vec_t e;
        n = 0;
        while (!bus4.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus4.done) begin
            check({name, "_done_timeout"}, 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else if (sb_q.size() == 0) begin
            check({name, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({name, "_latency"}, n, exp_lat);
            check({name, "_Y"}, bus4.Y, e.y);
            check({name, "_flags"}, {bus4.BorrowOUT, bus4.Overflow, bus4.Zero},
                  {e.bo, e.ov, e.zero});
        end
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus4.done) seen = 1'b1;
        end
        check(name, seen, 1'b0);
    endtask

    task automatic sweep_one(input logic [15:0] a, input logic [15:0] b,
                             input logic bin, input logic s);
        vec_t       e;
        logic [2:0] got;
        e   = ref_sub(a, b, bin, s);
        got = 3'b000;
        @(posedge clk); #1;
        bus16.A = a; bus16.B = b; bus16.BorrowIN = bin; bus16.sat = s; bus16.start = 1'b1;
        bus1.A  = a; bus1.B  = b; bus1.BorrowIN  = bin; bus1.sat  = s; bus1.start  = 1'b1;
        bus8.A  = a; bus8.B  = b; bus8.BorrowIN  = bin; bus8.sat  = s; bus8.start  = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        bus1.start  = 1'b0;
        bus8.start  = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus16.done && !got[0]) begin
                got[0] = 1'b1;
                check("c16_latency", n, 1);
                check("c16_result", {bus16.Y, bus16.BorrowOUT, bus16.Overflow, bus16.Zero},
                      {e.y, e.bo, e.ov, e.zero});
            end
            if (bus1.done && !got[1]) begin
                got[1] = 1'b1;
                check("c1_latency", n, 16);
                check("c1_result", {bus1.Y, bus1.BorrowOUT, bus1.Overflow, bus1.Zero},
                      {e.y, e.bo, e.ov, e.zero});
            end
            if (bus8.done && !got[2]) begin
                got[2] = 1'b1;
                check("c8_latency", n, 2);
                check("c8_result", {bus8.Y, bus8.BorrowOUT, bus8.Overflow, bus8.Zero},
                      {e.y, e.bo, e.ov, e.zero});
            end
        end
        if (!got[0]) check("c16_done_timeout", 32'd0, 32'd1);
        if (!got[1]) check("c1_done_timeout", 32'd0, 32'd1);
        if (!got[2]) check("c8_done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        logic [15:0] ra, rb;

        //          a         b         bin   sat   y         bo    ov    zero
        tbl[0]  = '{16'h0006, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{16'h0002, 16'h0006, 1'b0, 1'b0, 16'hFFFC, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{16'h7FFF, 16'h8000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{16'h0001, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{16'h8000, 16'h0000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        bus4.start  = 1'b0; bus4.A  = '0; bus4.B  = '0; bus4.BorrowIN  = 1'b0; bus4.sat  = 1'b0;
        bus16.start = 1'b0; bus16.A = '0; bus16.B = '0; bus16.BorrowIN = 1'b0; bus16.sat = 1'b0;
        bus1.start  = 1'b0; bus1.A  = '0; bus1.B  = '0; bus1.BorrowIN  = 1'b0; bus1.sat  = 1'b0;
        bus8.start  = 1'b0; bus8.A  = '0; bus8.B  = '0; bus8.BorrowIN  = 1'b0; bus8.sat  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_outputs",
              {bus4.busy, bus4.done, bus4.Y, bus4.BorrowOUT, bus4.Overflow, bus4.Zero}, 32'd0);

        // Directed table through the CHUNK=4 instance.
        for (int i = 0; i < 12; i++) begin
            start_main(tbl[i]);
            collect_main($sformatf("vec%0d", i), 4);
        end

        // start pulsed mid-RUN with new operands must be ignored; Y holds meanwhile.
        start_main(tbl[0]);
        @(posedge clk); #1;
        check("busy_in_run", bus4.busy, 1'b1);
        check("y_hold_in_run", bus4.Y, tbl[11].y);
        bus4.A = 16'hFFFF; bus4.B = 16'h0000; bus4.BorrowIN = 1'b1; bus4.sat = 1'b1;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        collect_main("midrun_start", 2);
        // start raised in the DONE cycle is also ignored.
        bus4.start = 1'b1;
        @(posedge clk); #1;
        check("start_in_done_busy", bus4.busy, 1'b0);
        bus4.start = 1'b0;
        expect_no_done("no_extra_done", 8);
        check("y_hold_idle", bus4.Y, 16'h0004);

        // Reset during RUN aborts with no done pulse; next op runs normally.
        start_main(tbl[1]);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_midrun_outputs",
              {bus4.busy, bus4.done, bus4.Y, bus4.BorrowOUT, bus4.Overflow, bus4.Zero}, 32'd0);
        #2;
        rst = 1'b0;
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        expect_no_done("rst_no_done", 8);
        start_main(tbl[3]);
        collect_main("after_rst", 4);

        // Random sweep across chunk sizes against the full-width reference.
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) begin ra = 16'h8000; rb = 16'h0001; end
            if (i == 1) begin ra = 16'h7FFF; rb = 16'hFFFF; end
            sweep_one(ra, rb, 1'($urandom_range(0, 1)), (i < 2) ? 1'b1 : 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
